apb_burst_reader: RTL
=====================

APB_BURST_READER -- requirements
Module: apb_burst_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max ACCESS-phase cycles waited for pready before abort (range 2..255).
REQ-002 SHALL have pclk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have presetn  input  1  synchronous active-low reset; one clock, synchronous and active-low.
REQ-004 SHALL have start  input  1  single-cycle burst request; sampled only in IDLE.
REQ-005 SHALL have start_addr  input  8  first register index of the burst.
REQ-006 SHALL have start_len  input  3  number of reads, 0..7.
REQ-007 SHALL have busy  output  1  high whenever not in IDLE.
REQ-008 SHALL have done  output  1  one-cycle pulse at burst end.
REQ-009 SHALL have err_slv  output  1  sticky, a beat returned pslverr; cleared on accepted start.
REQ-010 SHALL have err_tmo  output  1  sticky, pready timeout; cleared on accepted start.
REQ-011 SHALL have paddr  output  32  APB address, {24'h0, current index}.
REQ-012 SHALL have psel, penable  output  1 each  APB select / enable.
REQ-013 SHALL have pready, pslverr  input  1 each  APB slave ready / error.
REQ-014 SHALL have prdata  input  32  APB read data.
REQ-015 SHALL have out_valid  output  1  beat available.
REQ-016 SHALL have out_ready  input  1  consumer accepts beat.
REQ-017 SHALL have out_data  output  32, out_err  output  1  beat data and its pslverr flag.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS, OUT; all outputs registered.
REQ-019 IDLE: start=1 SHALL latch start_addr/start_len, clear err_slv/err_tmo; len>0 -> SETUP next cycle; len=0 -> stay IDLE, done pulse next cycle, no APB activity.
REQ-020 SETUP SHALL drive psel=1, penable=0, paddr=current index for exactly one cycle, then ACCESS.
REQ-021 ACCESS SHALL drive psel=1, penable=1, paddr unchanged until pready=1 sampled.
REQ-022 ACCESS with pready=1 SHALL capture prdata into out_data and pslverr into out_err, drop psel/penable next cycle, go OUT.
REQ-023 ACCESS wait counter SHALL count cycles with pready=0; after TIMEOUT such cycles -> drop psel/penable, set err_tmo, pulse done, IDLE, no beat.
REQ-024 OUT SHALL hold out_valid=1 with out_data/out_err stable and psel=0 until out_ready=1.
REQ-025 Handshake out_valid&&out_ready: decrement remaining, increment index modulo 256 (0xFF -> 0x00).
REQ-026 After handshake: out_err=1 -> set err_slv, terminate burst; remaining=0 -> terminate; else SETUP next cycle.
REQ-027 Terminate SHALL mean out_valid=0, done=1 for one cycle, state IDLE.
REQ-028 At least one idle APB cycle (psel=0) SHALL separate consecutive transfers.
REQ-029 start while busy SHALL be ignored; no queuing.
REQ-030 Latency: start at cycle T -> psel at T+1, penable at T+2; beat valid one cycle after pready sampled.

Reset
REQ-031 presetn=0 at a clock edge SHALL force IDLE and psel, penable, busy, done, out_valid, out_err, err_slv, err_tmo =0, paddr=0, out_data=0, counters=0.
REQ-032 Reset mid-transfer SHALL abort without done pulse; APB signals low from the next edge.

Verification
REQ-033 Against the constant-register slave: start_addr=0, start_len=4, out_ready=1 -> beats C90FDAA2, 2168C234, ADF85458, A2BB4A9A, out_err=0, one done, err flags 0.
REQ-034 start_addr=3, start_len=3 -> beat A2BB4A9A (out_err=0), beat at index 4 with out_err=1, burst stops (no third read), err_slv=1, done.
REQ-035 pready held 0, TIMEOUT=16 -> psel/penable drop after 16 ACCESS cycles, err_tmo=1, done, out_valid never high.
REQ-036 out_ready low 5 cycles during OUT -> psel stays 0, out_data constant, next SETUP one cycle after acceptance.
REQ-037 start_addr=FF, start_len=2 -> paddr 0xFF then 0x00; start_len=0 -> done one cycle later, psel never high.
REQ-038 presetn=0 during ACCESS -> psel=penable=busy=0 next edge, no done; new start afterwards runs normally.

Source files
------------

// File: rtl/apb_burst_reader.sv
// APB burst reader: issues up to seven consecutive APB reads starting at a
// register index and hands each beat to a valid/ready consumer before the next.
module apb_burst_reader #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        start,
   input  logic [7:0]  start_addr,
   input  logic [2:0]  start_len,
   output logic        busy,
   output logic        done,
   output logic        err_slv,
   output logic        err_tmo,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   input  logic        pready,
   input  logic        pslverr,
   input  logic [31:0] prdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_err
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned LEN_W  = 3;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      OUT    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [CNT_W-1:0]    wcnt_q, wcnt_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_slv_q, err_slv_d;
   logic                err_tmo_q, err_tmo_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_err_q, out_err_d;

   // Next-state and registered-output computation; outputs derive from state_d.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      wcnt_d      = wcnt_q;
      err_slv_d   = err_slv_q;
      err_tmo_d   = err_tmo_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d     = start_addr;
               rem_d     = start_len;
               err_slv_d = 1'b0;
               err_tmo_d = 1'b0;
               if (start_len != LEN_W'(0)) begin
                  state_d = SETUP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SETUP: begin
            wcnt_d  = CNT_W'(0);
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               out_data_d = prdata;
               out_err_d  = pslverr;
               state_d    = OUT;
            end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_tmo_d = 1'b1;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else begin
               wcnt_d = wcnt_q + CNT_W'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               rem_d = rem_q - LEN_W'(1);
               idx_d = idx_q + IDX_W'(1);
               if (out_err_q) begin
                  err_slv_d = 1'b1;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else if (rem_q == LEN_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = SETUP;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      psel_d      = (state_d == SETUP) || (state_d == ACCESS);
      penable_d   = (state_d == ACCESS);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == OUT);
      paddr_d     = {{(ADDR_W - IDX_W){1'b0}}, idx_d};
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         rem_q       <= '0;
         wcnt_q      <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_slv_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         wcnt_q      <= wcnt_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_slv_q   <= err_slv_d;
         err_tmo_q   <= err_tmo_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err_slv   = err_slv_q;
   assign err_tmo   = err_tmo_q;
   assign paddr     = paddr_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

endmodule
